// File: rtl/uart_rx_int.sv
// uart_rx_int: 8N1 UART receiver with a single-byte holding register, read
// back by the control unit at 0x70. Raises a one-cycle int_sig per accepted byte.
// Build option: define PARITY_EN for 8E1 frames. This adds a PARITY state
// between DATA and STOP and makes parity_err live.
module uart_rx_int #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        uart_read_end,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        int_sig,
  output logic        frame_err,
  output logic        overrun,
  output logic        parity_err
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q;
  logic             rx_m, rx_s;
  logic             accept_q, accept_d;
  logic             set_ferr;
  logic             ferr_q, ovr_q;
`ifdef PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             set_perr;
  logic             perr_q;
`endif

  // Two-flop synchroniser for the asynchronous serial pin; resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM state, bit-timing counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      accept_q <= 1'b0;
`ifdef PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      accept_q <= accept_d;
`ifdef PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state logic. The start bit is checked at mid-bit. Later bits are taken
  // one full bit period apart, so each sample also lands near mid-bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    accept_d = 1'b0;
    set_ferr = 1'b0;
`ifdef PARITY_EN
    par_bad_d = par_bad_q;
    set_perr  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rx_s};
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s) begin
            set_ferr = 1'b1;
          end
`ifdef PARITY_EN
          else if (par_bad_q) begin
            set_perr = 1'b1;
          end
`endif
          else begin
            accept_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register and flags. When a read coincides with an accept, the
  // slot counts as freed in that same cycle, so the new byte is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q   <= '0;
      rx_valid <= 1'b0;
      int_sig  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      int_sig <= 1'b0;
      if (uart_read_end) begin
        rx_valid <= 1'b0;
        ferr_q   <= 1'b0;
        ovr_q    <= 1'b0;
`ifdef PARITY_EN
        perr_q   <= 1'b0;
`endif
      end
      if (accept_q) begin
        if (!rx_valid || uart_read_end) begin
          hold_q   <= shift_q;
          rx_valid <= 1'b1;
          int_sig  <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
      if (set_ferr) ferr_q <= 1'b1;
`ifdef PARITY_EN
      if (set_perr) perr_q <= 1'b1;
`endif
    end
  end

  assign rx_data   = {24'b0, hold_q};
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_int.sv
// Directed bench for uart_rx_int with CLKS_PER_BIT=8.
module tb_uart_rx_int;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        uart_read_end;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        int_sig;
  logic        frame_err;
  logic        overrun;
  logic        parity_err;

  int errors = 0;
  int checks = 0;
  int int_cnt = 0;
  int int_hi = 0;
  logic int_prev = 1'b0;
  int base;

  uart_rx_int #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .uart_read_end(uart_read_end),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .int_sig(int_sig),
    .frame_err(frame_err),
    .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Counts int_sig pulses (rising edges) and the total number of high cycles.
  always @(posedge clk) begin
    if (int_sig && !int_prev) int_cnt = int_cnt + 1;
    if (int_sig) int_hi = int_hi + 1;
    int_prev = int_sig;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Sends a full frame. uart_read_end is pulsed during the accept cycle when
  // rend=1. Returns #1 after the edge at which rx_valid/int_sig update.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic rend);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef PARITY_EN
    send_bit(par);
`else
    if (par) begin end
`endif
    rx = stop;
    tick(CPB - 1);
    uart_read_end = rend;
    tick(1);
    uart_read_end = 1'b0;
  endtask

  task automatic read_pulse();
    uart_read_end = 1'b1;
    tick(1);
    uart_read_end = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    uart_read_end = 1'b0;
    tick(3);
    chk("reset_rx_data", rx_data, 32'h0);
    chk("reset_rx_valid", {31'b0, rx_valid}, 32'h0);
    chk("reset_int_sig", {31'b0, int_sig}, 32'h0);
    chk("reset_flags", {29'b0, frame_err, overrun, parity_err}, 32'h0);
    rst = 1'b0;
    tick(5);

    // 1: basic frame
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    chk("t1_rx_data", rx_data, 32'h000000A5);
    chk("t1_rx_valid", {31'b0, rx_valid}, 32'h1);
    chk("t1_int_high", {31'b0, int_sig}, 32'h1);
    tick(1);
    chk("t1_int_low", {31'b0, int_sig}, 32'h0);
    chk("t1_int_cnt", int_cnt, 1);
    read_pulse();
    chk("t1_read_valid", {31'b0, rx_valid}, 32'h0);
    chk("t1_read_data_kept", rx_data, 32'h000000A5);

    // 2: start-bit glitch
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    chk("t2_valid", {31'b0, rx_valid}, 32'h0);
    chk("t2_flags", {29'b0, frame_err, overrun, parity_err}, 32'h0);
    chk("t2_int_cnt", int_cnt, 1);

    // 3: framing error
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    chk("t3_frame_err", {31'b0, frame_err}, 32'h1);
    chk("t3_valid", {31'b0, rx_valid}, 32'h0);
    tick(12);
    chk("t3_int_cnt", int_cnt, 1);
    chk("t3_data_kept", rx_data, 32'h000000A5);
    read_pulse();
    chk("t3_frame_err_clr", {31'b0, frame_err}, 32'h0);

    // 4: overrun
    tick(4);
    base = int_cnt;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    chk("t4_first_int", {31'b0, int_sig}, 32'h1);
    tick(4);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    chk("t4_rx_data", rx_data, 32'h00000011);
    chk("t4_overrun", {31'b0, overrun}, 32'h1);
    chk("t4_no_int", {31'b0, int_sig}, 32'h0);
    tick(4);
    chk("t4_int_cnt", int_cnt - base, 1);
    read_pulse();
    chk("t4_valid_clr", {31'b0, rx_valid}, 32'h0);
    chk("t4_overrun_clr", {31'b0, overrun}, 32'h0);

    // 5: read coincides with accept
    tick(4);
    base = int_cnt;
    send_frame(8'h44, 1'b0, 1'b1, 1'b0);
    chk("t5_hold44", rx_data, 32'h00000044);
    tick(4);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    chk("t5_rx_data", rx_data, 32'h00000055);
    chk("t5_valid", {31'b0, rx_valid}, 32'h1);
    chk("t5_int", {31'b0, int_sig}, 32'h1);
    chk("t5_overrun", {31'b0, overrun}, 32'h0);
    tick(2);
    chk("t5_int_cnt", int_cnt - base, 2);

    // 6: reset mid-frame, then a clean frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    tick(2);
    chk("t6_rst_data", rx_data, 32'h0);
    chk("t6_rst_status", {27'b0, rx_valid, int_sig, frame_err, overrun, parity_err}, 32'h0);
    rst = 1'b0;
    rx = 1'b1;
    tick(10);
    chk("t6_no_partial", {31'b0, rx_valid}, 32'h0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    chk("t6_rx_data", rx_data, 32'h00000081);
    chk("t6_valid", {31'b0, rx_valid}, 32'h1);
    tick(2);

`ifdef PARITY_EN
    read_pulse();
    tick(4);
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    tick(2);
    chk("p_parity_err", {31'b0, parity_err}, 32'h1);
    chk("p_valid", {31'b0, rx_valid}, 32'h0);
    chk("p_data_kept", rx_data, 32'h00000081);
`else
    chk("parity_tied", {31'b0, parity_err}, 32'h0);
`endif

    chk("int_one_cycle", int_hi, int_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
